prbs13_checker: RTL and testbench

PRBS13_CHECKER -- requirements
Module: prbs13_checker

---
 rtl/prbs13_checker.sv | 141 ++++++++++++++
 tb/tb_prbs13_checker.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/prbs13_checker.sv
// PRBS13 checker: self-synchronising receiver for the x^13 PRBS stream.
// Seeds its LFSR from 13 received bits, then predicts every following
// bit, counting compared bits and mismatches. A sliding lock monitor drops
// back to seeding when too many errors land in one window.
// Optional first-error capture is built when PRBS13_CHK_FIRST_ERR_EN is
// defined; otherwise first_err_pos/first_err_vld are tied to 0.
module prbs13_checker #(
  parameter int CNT_W       = 32,
  parameter int WIN_LEN     = 64,
  parameter int LOSS_THRESH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             control,
  input  logic             clr,
  input  logic             rx_valid,
  input  logic             rx_bit,
  output logic             locked,
  output logic             sync_loss,
  output logic [CNT_W-1:0] bit_count,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] first_err_pos,
  output logic             first_err_vld
);

  localparam int WIN_W = $clog2(WIN_LEN);
  localparam int WE_W  = $clog2(LOSS_THRESH + 1);

  typedef enum logic [1:0] {IDLE, SEED, LOCKED} state_t;

  state_t           state, state_nxt;
  logic [12:0]      r;
  logic [3:0]       seed_cnt;
  logic [WIN_W-1:0] win_cnt;
  logic [WE_W-1:0]  win_err;
  logic             fb, mis, seed_done, seed_ok, cmp, loss;
  logic             locked_nxt, sync_loss_nxt;

  assign fb        = r[12] ^ r[3] ^ r[2] ^ r[0];
  assign mis       = rx_bit ^ fb;
  assign seed_done = (state == SEED) && rx_valid && (seed_cnt == 4'd12);
  assign seed_ok   = ({r[11:0], rx_bit} != 13'd0);
  // a compared bit: locked, enabled and qualified
  assign cmp       = control && (state == LOCKED) && rx_valid;
  assign loss      = cmp && mis && (win_err == WE_W'(LOSS_THRESH - 1));

  // state register
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // next-state decode; control=0 overrides everything
  always_comb begin
    state_nxt = state;
    if (!control) state_nxt = IDLE;
    else begin
      case (state)
        IDLE:    state_nxt = SEED;
        SEED:    if (seed_done && seed_ok) state_nxt = LOCKED;
        LOCKED:  if (loss) state_nxt = SEED;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // output decode, registered below so every output is a flop
  always_comb begin
    locked_nxt    = (state_nxt == LOCKED);
    sync_loss_nxt = loss;
  end

  // registered status outputs
  always_ff @(posedge clock) begin
    if (reset) begin
      locked    <= 1'b0;
      sync_loss <= 1'b0;
    end else begin
      locked    <= locked_nxt;
      sync_loss <= sync_loss_nxt;
    end
  end

  // LFSR, seed counter and lock-monitor window
  always_ff @(posedge clock) begin
    if (reset || !control) begin
      r        <= '0;
      seed_cnt <= '0;
      win_cnt  <= '0;
      win_err  <= '0;
    end else if (rx_valid) begin
      if (state == SEED) begin
        // seeding: received bits load the register directly
        r        <= {r[11:0], rx_bit};
        seed_cnt <= seed_done ? 4'd0 : seed_cnt + 4'd1;
      end else if (state == LOCKED) begin
        // locked: free-run on the prediction so errors don't propagate
        r <= {r[11:0], fb};
        if (loss) begin
          win_cnt  <= '0;
          win_err  <= '0;
          seed_cnt <= '0;
        end else if (win_cnt == WIN_W'(WIN_LEN - 1)) begin
          win_cnt <= '0;
          win_err <= '0;
        end else begin
          win_cnt <= win_cnt + 1'b1;
          win_err <= win_err + WE_W'(mis);
        end
      end
    end
  end

  // saturating bit/error counters; clr beats a coincident bit
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      bit_count <= '0;
      err_count <= '0;
    end else if (cmp) begin
      if (bit_count != '1)        bit_count <= bit_count + 1'b1;
      if (mis && err_count != '1) err_count <= err_count + 1'b1;
    end
  end

`ifdef PRBS13_CHK_FIRST_ERR_EN
  // capture the pre-increment bit_count of the first error since reset/clr
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      first_err_pos <= '0;
      first_err_vld <= 1'b0;
    end else if (cmp && mis && !first_err_vld) begin
      first_err_pos <= bit_count;
      first_err_vld <= 1'b1;
    end
  end
`else
  assign first_err_pos = '0;
  assign first_err_vld = 1'b0;
`endif

endmodule

// File: tb/tb_prbs13_checker.sv
// Bench for prbs13_checker: directed scenarios plus a randomized run, all
// checked against a stream-level reference model (bit history + recurrence).
module tb_prbs13_checker;

  localparam int WIN_LEN     = 64;
  localparam int LOSS_THRESH = 8;

  logic        clock = 1'b0;
  logic        reset, control, clr, rx_valid, rx_bit;
  logic        locked, sync_loss, first_err_vld;
  logic [31:0] bit_count, err_count, first_err_pos;

  int total = 0;
  int bad   = 0;

  prbs13_checker #(.CNT_W(32), .WIN_LEN(WIN_LEN), .LOSS_THRESH(LOSS_THRESH)) dut (
    .clock(clock), .reset(reset), .control(control), .clr(clr),
    .rx_valid(rx_valid), .rx_bit(rx_bit), .locked(locked), .sync_loss(sync_loss),
    .bit_count(bit_count), .err_count(err_count),
    .first_err_pos(first_err_pos), .first_err_vld(first_err_vld)
  );

  always #5 clock = ~clock;

`ifdef PRBS13_CHK_FIRST_ERR_EN
  localparam bit CAP_EN = 1'b1;
`else
  localparam bit CAP_EN = 1'b0;
`endif

  // ---------------- reference model ----------------
  // mode: 0 idle, 1 seeding, 2 locked. hist keeps the last 13 stream bits
  // (received while seeding, predicted while locked).
  int          m_mode, m_seed, m_win, m_werr;
  bit          hist[$];
  logic [31:0] m_bc, m_ec, m_fep;
  logic        m_fev, m_sl;

  // transmit-side PRBS generator: next bit = s[n-13]^s[n-4]^s[n-3]^s[n-1]
  bit g[$];

  function automatic bit gen_next();
    bit nb;
    nb = g[$-12] ^ g[$-3] ^ g[$-2] ^ g[$];
    g.push_back(nb);
    if (g.size() > 13) void'(g.pop_front());
    return nb;
  endfunction

  function automatic bit hist_nonzero();
    bit any = 1'b0;
    for (int i = 0; i < 13; i++) any |= hist[hist.size() - 1 - i];
    return any;
  endfunction

  task automatic model_edge();
    bit e, err;
    if (reset) begin
      m_mode = 0; m_seed = 0; m_win = 0; m_werr = 0; hist.delete();
      m_bc = 0; m_ec = 0; m_fep = 0; m_fev = 0; m_sl = 0;
      return;
    end
    m_sl = 0;
    if (clr) begin m_bc = 0; m_ec = 0; m_fep = 0; m_fev = 0; end
    if (!control) begin
      m_mode = 0; m_seed = 0; m_win = 0; m_werr = 0; hist.delete();
      return;
    end
    if (m_mode == 0) begin m_mode = 1; return; end
    if (!rx_valid) return;
    if (m_mode == 1) begin
      hist.push_back(rx_bit);
      m_seed++;
      if (m_seed == 13) begin
        m_seed = 0;
        if (hist_nonzero()) m_mode = 2;
      end
    end else begin
      e = hist[$-12] ^ hist[$-3] ^ hist[$-2] ^ hist[$];
      hist.push_back(e);
      err = (rx_bit != e);
      if (!clr) begin
        if (err && !m_fev && CAP_EN) begin m_fep = m_bc; m_fev = 1; end
        if (m_bc != 32'hFFFF_FFFF) m_bc++;
        if (err && m_ec != 32'hFFFF_FFFF) m_ec++;
      end
      m_win++;
      m_werr += int'(err);
      if (m_werr == LOSS_THRESH) begin
        m_mode = 1; m_sl = 1; m_win = 0; m_werr = 0; m_seed = 0;
      end else if (m_win == WIN_LEN) begin
        m_win = 0; m_werr = 0;
      end
    end
    while (hist.size() > 13) void'(hist.pop_front());
  endtask

  function automatic logic [98:0] dut_vec();
    return {locked, sync_loss, bit_count, err_count, first_err_pos, first_err_vld};
  endfunction

  function automatic logic [98:0] mdl_vec();
    return {(m_mode == 2), m_sl, m_bc, m_ec, m_fep, m_fev};
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic step(input bit v, input bit b);
    rx_valid = v;
    rx_bit   = b;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; control = 1; clr = 0;
    step(0, 0);
    reset = 0;
    step(0, 0);                     // IDLE -> SEED
  endtask

  // sends 0000000001111 (r = 0x000F) and primes the generator with it
  task automatic send_seed(input bit gaps);
    bit s[13] = '{0,0,0,0,0,0,0,0,0,1,1,1,1};
    g.delete();
    for (int i = 0; i < 13; i++) begin
      g.push_back(s[i]);
      step(1, s[i]);
      if (gaps) step(0, 1'($urandom));
    end
  endtask

  task automatic send_good(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      step(1, gen_next());
      if (gaps) step(0, 1'($urandom));
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1; control = 1; clr = 1;
    step(1, 1);
    step(1, 0);
    total++;
    if (dut_vec() !== 99'd0) begin
      bad++; $display("FAIL reset_state got=%h want=0", dut_vec());
    end
    reset = 0; clr = 0;
  endtask

  task automatic test_lock_clean();
    do_reset();
    send_seed(0);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL lock_after_seed got=%b want=1", locked); end
    send_good(1000, 0);
    total++;
    if (bit_count !== 32'd1000 || err_count !== 32'd0) begin
      bad++; $display("FAIL clean_counts got=%0d/%0d want=1000/0", bit_count, err_count);
    end
    total++;
    if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL clean_model got=%h want=%h", dut_vec(), mdl_vec()); end
  endtask

  task automatic test_errors();
    do_reset();
    send_seed(0);
    for (int i = 1; i <= 1000; i++) begin
      bit b = gen_next();
      step(1, (i == 10 || i == 20 || i == 30) ? ~b : b);
    end
    total++;
    if (bit_count !== 32'd1000 || err_count !== 32'd3) begin
      bad++; $display("FAIL err_counts got=%0d/%0d want=1000/3", bit_count, err_count);
    end
    total++;
    if (first_err_pos !== (CAP_EN ? 32'd9 : 32'd0) || first_err_vld !== CAP_EN) begin
      bad++; $display("FAIL first_err got=%0d/%b want=%0d/%b", first_err_pos, first_err_vld,
                      CAP_EN ? 9 : 0, CAP_EN);
    end
  endtask

  task automatic test_zero_seed();
    do_reset();
    for (int i = 0; i < 13; i++) step(1, 0);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL zero_seed_nolock got=%b want=0", locked); end
    send_seed(0);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL zero_seed_relock got=%b want=1", locked); end
  endtask

  task automatic test_sync_loss();
    int pulses = 0;
    int n = 0;
    logic [31:0] bc_hold, ec_hold;
    do_reset();
    send_seed(0);
    send_good(100, 0);
    while (pulses == 0 && n < 200) begin
      void'(gen_next());
      step(1, n[0] ? 1'b0 : 1'b1);
      if (sync_loss) pulses++;
      n++;
    end
    total++;
    if (pulses != 1 || locked !== 1'b0) begin
      bad++; $display("FAIL sync_loss_pulse got=%0d/%b want=1/0 bits=%0d", pulses, locked, n);
    end
    bc_hold = bit_count; ec_hold = err_count;
    total++;
    if (dut_vec() !== mdl_vec()) begin bad++; $display("FAIL loss_model got=%h want=%h", dut_vec(), mdl_vec()); end
    send_good(12, 0);
    total++;
    if (sync_loss !== 1'b0 || locked !== 1'b0 || bit_count !== bc_hold || err_count !== ec_hold) begin
      bad++; $display("FAIL loss_frozen got=%b/%b/%0d/%0d want=0/0/%0d/%0d",
                      sync_loss, locked, bit_count, err_count, bc_hold, ec_hold);
    end
    send_good(1, 0);
    total++;
    if (locked !== 1'b1) begin bad++; $display("FAIL relock got=%b want=1", locked); end
    send_good(30, 0);
    total++;
    if (bit_count !== bc_hold + 32'd30 || err_count !== ec_hold) begin
      bad++; $display("FAIL relock_counts got=%0d/%0d want=%0d/%0d",
                      bit_count, err_count, bc_hold + 30, ec_hold);
    end
  endtask

  task automatic test_valid_gaps();
    do_reset();
    send_seed(1);
    send_good(187, 1);
    total++;
    if (bit_count !== 32'd187 || err_count !== 32'd0 || locked !== 1'b1) begin
      bad++; $display("FAIL gaps_counts got=%0d/%0d/%b want=187/0/1", bit_count, err_count, locked);
    end
  endtask

  task automatic test_reset_clr();
    do_reset();
    send_seed(0);
    send_good(500, 0);
    reset = 1;
    step(1, gen_next());
    total++;
    if (dut_vec() !== 99'd0) begin bad++; $display("FAIL midrun_reset got=%h want=0", dut_vec()); end
    reset = 0;
    send_good(10, 0);
    total++;
    if (locked !== 1'b0) begin bad++; $display("FAIL reseed_needed got=%b want=0", locked); end
    do_reset();
    send_seed(0);
    send_good(10, 0);
    clr = 1;
    step(1, ~gen_next());
    clr = 0;
    total++;
    if (bit_count !== 32'd0 || err_count !== 32'd0 || first_err_vld !== 1'b0 || locked !== 1'b1) begin
      bad++; $display("FAIL clr_wins got=%0d/%0d/%b/%b want=0/0/0/1",
                      bit_count, err_count, first_err_vld, locked);
    end
    send_good(5, 0);
    total++;
    if (bit_count !== 32'd5 || err_count !== 32'd0) begin
      bad++; $display("FAIL after_clr got=%0d/%0d want=5/0", bit_count, err_count);
    end
  endtask

  task automatic test_random();
    int err_pct;
    do_reset();
    send_seed(0);
    for (int i = 0; i < 4000; i++) begin
      if (i % 500 == 0) err_pct = $urandom_range(0, 25);
      control = ($urandom_range(0, 299) != 0);
      clr     = ($urandom_range(0, 199) == 0);
      if ($urandom_range(0, 3) != 0) begin
        bit b = gen_next();
        step(1, ($urandom_range(0, 99) < err_pct) ? ~b : b);
      end else begin
        step(0, 1'($urandom));
      end
      total++;
      if (dut_vec() !== mdl_vec()) begin
        bad++; $display("FAIL random_cycle%0d got=%h want=%h", i, dut_vec(), mdl_vec());
      end
    end
    control = 1; clr = 0;
  endtask

  initial begin
    reset = 1; control = 0; clr = 0; rx_valid = 0; rx_bit = 0;
    test_reset();
    test_lock_clean();
    test_errors();
    test_zero_seed();
    test_sync_loss();
    test_valid_gaps();
    test_reset_clr();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
